// File: rtl/readout_channel_merger.sv
// ---------------------------------------------------------------------------
// readout_channel_merger
//
// Merges NCHAN independent readout channels into one downstream write port.
// Each channel owns a small FIFO of DEPTH words; a round-robin arbiter pops
// one word per cycle (when the downstream FIFO is not full) and presents it
// on a registered output.
//
// Optional feature: define MERGER_OVERFLOW_REPORT_EN to keep a 16-bit
// saturating drop counter and a report-pending flag per channel. A granted
// channel with the flag set emits a report word
// {8'hEE, channel, zeros, drop_count} instead of popping data.
//
// Ports
//   clock          : the only clock
//   reset          : synchronous, active-high reset
//   enable         : global accept enable for new words
//   trigger_chip   : when 0, granted words are popped and discarded
//   chan_mask      : per-channel accept enable
//   block_update   : per-channel one-cycle word-valid strobe
//   datain         : channel c word at [c*DATA_WIDTH +: DATA_WIDTH]
//   FIFO_full      : downstream FIFO full, suppresses all grants
//   FIFO_data_out  : merged word (held between grants)
//   FIFO_chan      : source channel of FIFO_data_out
//   FIFO_wr_enable : downstream write strobe
//   overflow       : sticky per-channel drop flag
// ---------------------------------------------------------------------------
module readout_channel_merger #(
    parameter int NCHAN      = 4,
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 64,
    localparam int CHW       = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        trigger_chip,
    input  logic [NCHAN-1:0]            chan_mask,
    input  logic [NCHAN-1:0]            block_update,
    input  logic [NCHAN*DATA_WIDTH-1:0] datain,
    input  logic                        FIFO_full,
    output logic [DATA_WIDTH-1:0]       FIFO_data_out,
    output logic [CHW-1:0]              FIFO_chan,
    output logic                        FIFO_wr_enable,
    output logic [NCHAN-1:0]            overflow
);

    localparam int         AW        = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);

    // Input capture stage: the strobe is registered before it reaches the
    // channel FIFO, which gives the two-edge strobe-to-write latency.
    logic [NCHAN-1:0]            r_in_valid;
    logic [NCHAN*DATA_WIDTH-1:0] r_in_data;

    // Channel FIFOs: pointers carry one extra wrap bit so full/empty are
    // distinguishable without a separate count.
    logic [DATA_WIDTH-1:0] r_mem  [NCHAN][DEPTH];
    logic [AW:0]           r_wptr [NCHAN];
    logic [AW:0]           r_rptr [NCHAN];

    logic [CHW-1:0]        r_last_grant;
    logic [NCHAN-1:0]      r_overflow;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic [CHW-1:0]        r_chan;
    logic                  r_wr_enable;

    logic [NCHAN-1:0]      w_not_empty;
    logic [NCHAN-1:0]      w_full;
    logic [NCHAN-1:0]      w_push;
    logic [NCHAN-1:0]      w_drop;
    logic [NCHAN-1:0]      w_eligible;
    logic [NCHAN-1:0]      w_pop;
    logic                  w_grant_valid;
    logic [CHW-1:0]        w_grant_idx;
    logic [DATA_WIDTH-1:0] w_grant_word;

`ifdef MERGER_OVERFLOW_REPORT_EN
    logic [15:0]           r_drop_cnt [NCHAN];
    logic [NCHAN-1:0]      r_rpt_pend;
    logic [NCHAN-1:0]      w_rpt_clear;
    logic                  w_report_sel;
`endif

    // Per-channel occupancy status and push/drop decision on pre-edge state.
    always_comb begin
        w_not_empty = '0;
        w_full      = '0;
        w_push      = '0;
        w_drop      = '0;
        for (int c = 0; c < NCHAN; c++) begin
            w_not_empty[c] = (r_wptr[c] != r_rptr[c]);
            w_full[c]      = ((r_wptr[c] - r_rptr[c]) == DEPTH_CNT);
            w_push[c]      = r_in_valid[c] & ~w_full[c];
            w_drop[c]      = r_in_valid[c] &  w_full[c];
        end
    end

`ifdef MERGER_OVERFLOW_REPORT_EN
    assign w_eligible = w_not_empty | r_rpt_pend;
`else
    assign w_eligible = w_not_empty;
`endif

    // Round-robin search starting at last_grant+1, wrapping modulo NCHAN.
    always_comb begin
        int j;
        j             = 0;
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        for (int i = 1; i <= NCHAN; i++) begin
            j = int'(r_last_grant) + i;
            if (j >= NCHAN) begin
                j = j - NCHAN;
            end else begin
                j = j;
            end
            if (!w_grant_valid && !FIFO_full && w_eligible[j]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = CHW'(j);
            end else begin
                w_grant_valid = w_grant_valid;
            end
        end
    end

    // Grant decode: choose between a report word and a data pop.
    always_comb begin
        w_pop        = '0;
        w_grant_word = r_mem[w_grant_idx][r_rptr[w_grant_idx][AW-1:0]];
`ifdef MERGER_OVERFLOW_REPORT_EN
        w_rpt_clear  = '0;
        w_report_sel = w_grant_valid & r_rpt_pend[w_grant_idx];
        if (w_report_sel) begin
            w_grant_word                    = '0;
            w_grant_word[DATA_WIDTH-1 -: 8] = 8'hEE;
            w_grant_word[DATA_WIDTH-9 -: 8] = 8'(w_grant_idx);
            w_grant_word[15:0]              = r_drop_cnt[w_grant_idx];
            w_rpt_clear[w_grant_idx]        = 1'b1;
        end else if (w_grant_valid) begin
            w_pop[w_grant_idx] = 1'b1;
        end else begin
            w_pop = '0;
        end
`else
        if (w_grant_valid) begin
            w_pop[w_grant_idx] = 1'b1;
        end else begin
            w_pop = '0;
        end
`endif
    end

    // Input capture register; masking is applied when the strobe is sampled.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_in_valid <= '0;
            r_in_data  <= '0;
        end else begin
            r_in_valid <= block_update & chan_mask & {NCHAN{enable}};
            r_in_data  <= datain;
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clock) begin
        for (int c = 0; c < NCHAN; c++) begin
            if (w_push[c]) begin
                r_mem[c][r_wptr[c][AW-1:0]] <= r_in_data[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // FIFO pointers and sticky overflow flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int c = 0; c < NCHAN; c++) begin
                r_wptr[c] <= '0;
                r_rptr[c] <= '0;
            end
            r_overflow <= '0;
        end else begin
            for (int c = 0; c < NCHAN; c++) begin
                if (w_push[c]) begin
                    r_wptr[c] <= r_wptr[c] + PTR_ONE;
                end
                if (w_pop[c]) begin
                    r_rptr[c] <= r_rptr[c] + PTR_ONE;
                end
            end
            r_overflow <= r_overflow | w_drop;
        end
    end

    // Registered output stage and arbitration pointer.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_last_grant <= CHW'(NCHAN - 1);
            r_data_out   <= '0;
            r_chan       <= '0;
            r_wr_enable  <= 1'b0;
        end else if (w_grant_valid) begin
            r_last_grant <= w_grant_idx;
            r_data_out   <= w_grant_word;
            r_chan       <= w_grant_idx;
            r_wr_enable  <= trigger_chip;
        end else begin
            r_wr_enable  <= 1'b0;
        end
    end

`ifdef MERGER_OVERFLOW_REPORT_EN
    // Drop counters and report flags; a drop coinciding with the report
    // restarts the count at one rather than being lost.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int c = 0; c < NCHAN; c++) begin
                r_drop_cnt[c] <= 16'd0;
            end
            r_rpt_pend <= '0;
        end else begin
            for (int c = 0; c < NCHAN; c++) begin
                if (w_drop[c]) begin
                    r_rpt_pend[c] <= 1'b1;
                    if (w_rpt_clear[c]) begin
                        r_drop_cnt[c] <= 16'd1;
                    end else if (r_drop_cnt[c] != 16'hFFFF) begin
                        r_drop_cnt[c] <= r_drop_cnt[c] + 16'd1;
                    end
                end else if (w_rpt_clear[c]) begin
                    r_rpt_pend[c] <= 1'b0;
                    r_drop_cnt[c] <= 16'd0;
                end
            end
        end
    end
`endif

    assign FIFO_data_out  = r_data_out;
    assign FIFO_chan      = r_chan;
    assign FIFO_wr_enable = r_wr_enable;
    assign overflow       = r_overflow;

endmodule

// File: tb/tb_readout_channel_merger.sv
// ---------------------------------------------------------------------------
// Testbench for readout_channel_merger (NCHAN=4, DEPTH=4, DATA_WIDTH=64).
// Every cycle the DUT outputs are compared against a queue-based reference
// model; a cycle table and hand-written sequences add constant expectations.
// Honours MERGER_OVERFLOW_REPORT_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_readout_channel_merger;

    localparam int NCH   = 4;
    localparam int DEP   = 4;
    localparam int DW    = 64;
`ifdef MERGER_OVERFLOW_REPORT_EN
    localparam bit REPORT_EN = 1'b1;
`else
    localparam bit REPORT_EN = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset;
    logic              enable;
    logic              trigger_chip;
    logic [NCH-1:0]    chan_mask;
    logic [NCH-1:0]    block_update;
    logic [NCH*DW-1:0] datain;
    logic              FIFO_full;
    logic [DW-1:0]     FIFO_data_out;
    logic [1:0]        FIFO_chan;
    logic              FIFO_wr_enable;
    logic [NCH-1:0]    overflow;

    readout_channel_merger #(.NCHAN(NCH), .DEPTH(DEP), .DATA_WIDTH(DW)) dut (
        .clock(clock), .reset(reset), .enable(enable), .trigger_chip(trigger_chip),
        .chan_mask(chan_mask), .block_update(block_update), .datain(datain),
        .FIFO_full(FIFO_full), .FIFO_data_out(FIFO_data_out), .FIFO_chan(FIFO_chan),
        .FIFO_wr_enable(FIFO_wr_enable), .overflow(overflow)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DW-1:0]  mq [NCH][$];
    int             m_last = NCH - 1;
    logic [NCH-1:0] m_ovf = '0;
    int             m_cnt [NCH];
    bit             m_pend [NCH];
    logic           m_we = 1'b0;
    logic [1:0]     m_ch = 2'd0;
    logic [DW-1:0]  m_d = '0;
    logic [NCH-1:0] m_arr_bu = '0;      // strobes sampled at the previous edge
    logic [DW-1:0]  m_arr_d [NCH];

    logic [65:0]    seen [$];           // {chan, data} of every write observed

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock edge of the specification: grant on pre-edge state, then the
    // words sampled at the previous edge arrive at their channel.
    function automatic void model_edge();
        int sz [NCH];
        int g;
        if (reset) begin
            for (int c = 0; c < NCH; c++) begin
                mq[c].delete();
                m_cnt[c]  = 0;
                m_pend[c] = 1'b0;
            end
            m_last = NCH - 1; m_ovf = '0; m_we = 1'b0; m_ch = 2'd0; m_d = '0; m_arr_bu = '0;
            return;
        end
        for (int c = 0; c < NCH; c++) sz[c] = mq[c].size();
        g = -1;
        if (!FIFO_full) begin
            for (int i = 1; i <= NCH; i++) begin
                int c;
                c = (m_last + i) % NCH;
                if (g < 0 && (sz[c] > 0 || m_pend[c])) g = c;
            end
        end
        if (g >= 0) begin
            m_ch = 2'(g); m_we = trigger_chip; m_last = g;
            if (m_pend[g]) begin
                m_d = {8'hEE, 8'(g), 32'h0, 16'(m_cnt[g])};
                m_pend[g] = 1'b0; m_cnt[g] = 0;
            end else begin
                m_d = mq[g].pop_front();
            end
        end else begin
            m_we = 1'b0;
        end
        for (int c = 0; c < NCH; c++) begin
            if (m_arr_bu[c]) begin
                if (sz[c] >= DEP) begin
                    m_ovf[c] = 1'b1;
                    if (REPORT_EN) begin
                        m_pend[c] = 1'b1;
                        if (m_cnt[c] < 65535) m_cnt[c] = m_cnt[c] + 1;
                    end
                end else begin
                    mq[c].push_back(m_arr_d[c]);
                end
            end
        end
        m_arr_bu = block_update & chan_mask & {NCH{enable}};
        for (int c = 0; c < NCH; c++) m_arr_d[c] = datain[c*DW +: DW];
    endfunction

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
        check("model", {57'h0, FIFO_wr_enable, FIFO_chan, FIFO_data_out, overflow},
                       {57'h0, m_we, m_ch, m_d, m_ovf});
        if (FIFO_wr_enable) seen.push_back({FIFO_chan, FIFO_data_out});
    endtask

    task automatic do_reset();
        reset = 1'b1; block_update = '0;
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        logic          rst;
        logic [3:0]    bu;
        logic [DW-1:0] d;
        logic          exp_we;
        logic [1:0]    exp_ch;
        logic [DW-1:0] exp_d;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic [3:0] bu, input logic [DW-1:0] d,
                                input logic we, input logic [1:0] ch, input logic [DW-1:0] ed);
        vec_t v;
        v.rst = rst; v.bu = bu; v.d = d; v.exp_we = we; v.exp_ch = ch; v.exp_d = ed;
        return v;
    endfunction

    vec_t          vt [14];
    logic [DW-1:0] exp_q [$];
    bit            ff_state;

    initial begin
        reset = 1'b1; enable = 1'b1; trigger_chip = 1'b1; chan_mask = 4'hF;
        block_update = 4'h0; datain = '0; FIFO_full = 1'b0;

        // Channel c receives d + c. Expected outputs are sampled after each edge.
        vt[0]  = mk(1'b1, 4'h0, 64'h0,                   1'b0, 2'd0, 64'h0);
        vt[1]  = mk(1'b0, 4'h0, 64'h0,                   1'b0, 2'd0, 64'h0);
        vt[2]  = mk(1'b0, 4'h4, 64'h1111_2222_3333_4442, 1'b0, 2'd0, 64'h0);
        vt[3]  = mk(1'b0, 4'h0, 64'h0,                   1'b0, 2'd0, 64'h0);
        vt[4]  = mk(1'b0, 4'h0, 64'h0,                   1'b1, 2'd2, 64'h1111_2222_3333_4444);
        vt[5]  = mk(1'b0, 4'h0, 64'h0,                   1'b0, 2'd2, 64'h1111_2222_3333_4444);
        vt[6]  = mk(1'b1, 4'h0, 64'h0,                   1'b0, 2'd0, 64'h0);
        vt[7]  = mk(1'b0, 4'hF, 64'hA0,                  1'b0, 2'd0, 64'h0);
        vt[8]  = mk(1'b0, 4'h0, 64'h0,                   1'b0, 2'd0, 64'h0);
        vt[9]  = mk(1'b0, 4'h0, 64'h0,                   1'b1, 2'd0, 64'hA0);
        vt[10] = mk(1'b0, 4'h0, 64'h0,                   1'b1, 2'd1, 64'hA1);
        vt[11] = mk(1'b0, 4'h0, 64'h0,                   1'b1, 2'd2, 64'hA2);
        vt[12] = mk(1'b0, 4'h0, 64'h0,                   1'b1, 2'd3, 64'hA3);
        vt[13] = mk(1'b0, 4'h0, 64'h0,                   1'b0, 2'd3, 64'hA3);

        for (int i = 0; i < 14; i++) begin
            reset = vt[i].rst; block_update = vt[i].bu;
            for (int c = 0; c < NCH; c++) datain[c*DW +: DW] = vt[i].d + 64'(c);
            tick();
            check($sformatf("table[%0d]", i), {61'h0, FIFO_wr_enable, FIFO_chan, FIFO_data_out},
                  {61'h0, vt[i].exp_we, vt[i].exp_ch, vt[i].exp_d});
        end

        // Overflow: 6 words into ch0 while downstream is full.
        do_reset();
        FIFO_full = 1'b1;
        for (int i = 0; i < 6; i++) begin
            block_update = 4'h1; datain[DW-1:0] = 64'hD000 + 64'(i);
            tick();
        end
        block_update = 4'h0;
        tick(); tick();
        check("ovf_flag", 128'(overflow), 128'(4'b0001));
        seen.delete();
        FIFO_full = 1'b0;
        for (int k = 0; k < 12; k++) tick();
        exp_q.delete();
        if (REPORT_EN) exp_q.push_back(64'hEE00_0000_0000_0002);
        for (int i = 0; i < 4; i++) exp_q.push_back(64'hD000 + 64'(i));
        check("ovf_count", 128'(seen.size()), 128'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < seen.size(); i++)
            check($sformatf("ovf_word[%0d]", i), 128'(seen[i]), {62'h0, 2'd0, exp_q[i]});

        // Discard while trigger_chip is low.
        do_reset();
        trigger_chip = 1'b0; seen.delete();
        for (int i = 0; i < 3; i++) begin
            block_update = 4'h2; datain[DW +: DW] = 64'hBEEF_0000 + 64'(i);
            tick();
        end
        block_update = 4'h0;
        for (int k = 0; k < 6; k++) tick();
        check("discard_nowr", 128'(seen.size()), 128'(0));
        trigger_chip = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        check("discard_empty", 128'(seen.size()), 128'(0));

        // Masked channel produces nothing.
        do_reset();
        seen.delete(); chan_mask = 4'b1110;
        block_update = 4'h1; datain[DW-1:0] = 64'h5555;
        tick();
        block_update = 4'h0;
        for (int k = 0; k < 5; k++) tick();
        check("mask_nowr", 128'(seen.size()), 128'(0));
        check("mask_ovf", 128'(overflow), 128'(0));
        chan_mask = 4'hF;

        // Reset in the middle of a 3-word drain.
        do_reset();
        seen.delete();
        for (int i = 0; i < 3; i++) begin
            block_update = 4'h8; datain[3*DW +: DW] = 64'h7700 + 64'(i);
            tick();
        end
        block_update = 4'h0;
        for (int k = 0; k < 10 && seen.size() == 0; k++) tick();
        check("drain_start", 128'(seen.size() > 0), 128'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_outputs", {57'h0, FIFO_wr_enable, FIFO_chan, FIFO_data_out, overflow}, 128'h0);
        seen.delete();
        for (int k = 0; k < 8; k++) tick();
        check("rst_nowr", 128'(seen.size()), 128'(0));

        // Randomized traffic against the reference model.
        ff_state = 1'b0;
        for (int k = 0; k < 1500; k++) begin
            reset        = ($urandom_range(0, 199) == 0);
            block_update = 4'($urandom);
            chan_mask    = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
            enable       = ($urandom_range(0, 9) != 0);
            trigger_chip = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) ff_state = ~ff_state;
            FIFO_full    = ff_state;
            for (int c = 0; c < NCH; c++) datain[c*DW +: DW] = {$urandom, $urandom};
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/readout_channel_merger.md
READOUT_CHANNEL_MERGER -- requirements
Module: readout_channel_merger

Interface
REQ-001 SHALL have parameter NCHAN, default 4: number of receive channels, range 2..256.
REQ-002 SHALL have parameter DEPTH, default 8: words per channel FIFO, a power of 2, at least 2.
REQ-003 SHALL have parameter DATA_WIDTH, default 64: word width, at least 32.
REQ-004 SHALL define CHW = max(1, clog2(NCHAN)).
REQ-005 SHALL have port clock, input, 1: the only clock.
REQ-006 SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port enable, input, 1: accept new words.
REQ-008 SHALL have port trigger_chip, input, 1: gates FIFO writes.
REQ-009 SHALL have port chan_mask, input, NCHAN: per-channel accept enable.
REQ-010 SHALL have port block_update, input, NCHAN: one-cycle word-valid strobe per channel.
REQ-011 SHALL have port datain, input, NCHAN*DATA_WIDTH: channel c word at [c*DATA_WIDTH +: DATA_WIDTH].
REQ-012 SHALL have port FIFO_full, input, 1: downstream FIFO full.
REQ-013 SHALL have port FIFO_data_out, output, DATA_WIDTH: merged word.
REQ-014 SHALL have port FIFO_chan, output, CHW: source channel of FIFO_data_out.
REQ-015 SHALL have port FIFO_wr_enable, output, 1: write strobe.
REQ-016 SHALL have port overflow, output, NCHAN: sticky per-channel drop flag.

Function
REQ-017 SHALL give each channel its own FIFO of DEPTH words.
- push when block_update[c] & chan_mask[c] & enable & not full;
- occupancy is evaluated before the current edge.
REQ-018 SHALL drop a word that arrives when its channel FIFO is full.
- sets overflow[c];
- a push and a pop on the same cycle to a full FIFO still drops the word.
REQ-019 SHALL NOT bypass an empty FIFO: a word is poppable at the earliest on the cycle after it is pushed.
REQ-020 SHALL arbitrate round-robin.
- a channel is eligible when it is non-empty (or has a report pending, REQ-029);
- in each cycle with FIFO_full=0 and at least one eligible channel, grant the first eligible channel searching from last_grant+1 modulo NCHAN;
- pop one word from the granted channel;
- update last_grant.
REQ-021 SHALL NOT grant or pop in any cycle with FIFO_full=1.
REQ-022 SHALL register the output. A grant in cycle t drives the following at edge t+1:
- FIFO_data_out = popped word;
- FIFO_chan = granted channel;
- FIFO_wr_enable = trigger_chip sampled in cycle t.
REQ-023 SHALL pop and discard granted words while trigger_chip=0, with FIFO_wr_enable held at 0.
REQ-024 SHALL produce output with latency 2: a strobe sampled at edge t with an otherwise idle merger produces FIFO_wr_enable=1 after edge t+2.
REQ-025 SHALL keep draining stored words when enable=0 or chan_mask bits are 0; only new pushes are blocked.
REQ-026 SHALL hold FIFO_data_out and FIFO_chan in cycles without a grant, with FIFO_wr_enable=0.

Reset
REQ-027 SHALL, on reset=1 at an edge:
- empty all FIFOs;
- set last_grant=NCHAN-1;
- set FIFO_wr_enable=0, FIFO_data_out=0, FIFO_chan=0 and overflow=0;
- clear drop counters and report flags.
Reset takes precedence over simultaneous push, pop or grant, including mid-drain.

Configuration
REQ-028 SHALL use macro MERGER_OVERFLOW_REPORT_EN.
REQ-029 With MERGER_OVERFLOW_REPORT_EN defined, SHALL keep per channel a 16-bit saturating drop counter and a report-pending flag.
- each dropped word increments the counter and sets the flag;
- a granted channel with the flag set emits a report word instead of popping data;
- the report word has [DATA_WIDTH-1:DATA_WIDTH-8]=8'hEE, [DATA_WIDTH-9:DATA_WIDTH-16]=channel zero-extended, [15:0]=drop count, all other bits 0;
- FIFO_chan = channel;
- emitting the report clears the flag and the counter in the same cycle; a drop in that cycle counts 1 afresh;
- overflow stays sticky.
REQ-030 Without MERGER_OVERFLOW_REPORT_EN, SHALL implement no counters, flags or report words; eligibility is non-empty only.

Verification
REQ-031 SHALL cover a single word: NCHAN=4, DEPTH=4. block_update[2] with 64'h1111_2222_3333_4444 sampled at edge 10 -> FIFO_wr_enable=1 after edge 12 with that data, FIFO_chan=2, one cycle only.
REQ-032 SHALL cover simultaneous strobes: all four channels strobed together after reset -> outputs ch0, ch1, ch2, ch3 on four consecutive cycles.
REQ-033 SHALL cover overflow:
- FIFO_full=1 while 6 words are strobed into ch0 -> 4 stored, overflow=4'b0001;
- after release with macro: first word 64'hEE00_0000_0000_0002, then the 4 data words;
- without macro: the 4 data words only.
REQ-034 SHALL cover discard: trigger_chip=0 with 3 words queued -> 3 pops, FIFO_wr_enable stays 0, all FIFOs empty afterwards.
REQ-035 SHALL cover masking and reset:
- chan_mask=4'b1110 and block_update[0] pulsed -> no output;
- reset asserted during a 3-word drain -> after that edge all outputs are 0, no further writes.
